// File: rtl/pid_pkg.sv
// Shared definitions for the PID-to-PWM stage.
// Holds the default datapath widths and the duty mapping, which clamps the
// signed PID output to a non-negative value and shifts it down to PWM
// resolution.
package pid_pkg;

    localparam int DEF_ADC_BITWIDTH = 8;
    localparam int DEF_PWM_BITWIDTH = 4;

    // The operand is sign-extended to 32 bits by the caller, so one function
    // serves any ADC/PWM width pair. Negative values clamp to 0. The result
    // is truncated, never rounded.
    function automatic logic [31:0] sat_duty(input logic signed [31:0] pid_val,
                                             input int adc_bits,
                                             input int pwm_bits);
        logic [31:0] mask;
        logic [31:0] sat;
        mask = (32'd1 << adc_bits) - 32'd1;
        sat  = (pid_val < 0) ? 32'd0 : (pid_val & mask);
        return sat >> (adc_bits - pwm_bits);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Modulo-PRESCALE counter that paces the PWM tick counter.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   run_i   count enable; while low the counter is held at 0
//   tick_o  high in the last clock of each PRESCALE-clock interval
module pwm_prescaler #(
    parameter int PRESCALE = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int              PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;

    assign tick_o = run_i && (psc == PSC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i || tick_o) begin
            psc <= '0;
        end else begin
            psc <= psc + PSC_W'(1);
        end
    end

endmodule

// File: rtl/pid_pwm_gen.sv
// PWM generator downstream of the PID core in the fan controller.
// Clamps the signed PID output to a duty value, produces the fan PWM and
// paces the PID core with a clock-enable pulse every PID_DIV PWM periods.
// Duty is only taken up at period boundaries so the output has no runt pulses.
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   en_i            PWM enable
//   pid_val_i       signed PID output, ADC_BITWIDTH+1 bits
//   pwm_o           fan PWM output
//   clk_en_PID_o    one-cycle enable pulse to the PID core
//   duty_o          currently active duty value
//   period_start_o  one-cycle pulse in the first clock of each period
module pid_pwm_gen
    import pid_pkg::*;
#(
    parameter int ADC_BITWIDTH = DEF_ADC_BITWIDTH,
    parameter int PWM_BITWIDTH = DEF_PWM_BITWIDTH,
    parameter int PRESCALE     = 2,
    parameter int PID_DIV      = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic signed [ADC_BITWIDTH:0]   pid_val_i,
    output logic                           pwm_o,
    output logic                           clk_en_PID_o,
    output logic        [PWM_BITWIDTH-1:0] duty_o,
    output logic                           period_start_o
);

    localparam logic [PWM_BITWIDTH-1:0] CNT_LAST  = PWM_BITWIDTH'(2**PWM_BITWIDTH - 2);
    localparam int                      PDIV_W    = (PID_DIV > 1) ? $clog2(PID_DIV) : 1;
    localparam logic [PDIV_W-1:0]       PDIV_LAST = PDIV_W'(PID_DIV - 1);

    logic                    en_q;
    logic                    run;
    logic                    tick;
    logic                    wrap;
    logic [PWM_BITWIDTH-1:0] cnt;
    logic [PWM_BITWIDTH-1:0] duty_q;
    logic [PWM_BITWIDTH-1:0] duty_next;
    logic [PDIV_W-1:0]       pdiv;

    assign duty_next = PWM_BITWIDTH'(sat_duty(32'(pid_val_i), ADC_BITWIDTH, PWM_BITWIDTH));

    // Counting only starts once the registered enable is also high, so the
    // first period after enable (or reset release) has the same length as a
    // steady-state one: cnt=0 lasts a full PRESCALE clocks.
    assign run  = en_i && en_q;
    assign wrap = tick && (cnt == CNT_LAST);

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run_i  (run),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q           <= 1'b0;
            cnt            <= '0;
            pdiv           <= '0;
            duty_q         <= '0;
            clk_en_PID_o   <= 1'b0;
            period_start_o <= 1'b0;
        end else begin
            en_q           <= en_i;
            period_start_o <= wrap || (en_i && !en_q);
            clk_en_PID_o   <= wrap && (pdiv == PDIV_LAST);
            if (!run) begin
                // Idle: hold counters and let the shadow follow the PID value,
                // so a re-enable starts with the current duty.
                cnt    <= '0;
                pdiv   <= '0;
                duty_q <= duty_next;
            end else if (wrap) begin
                cnt    <= '0;
                duty_q <= duty_next;
                pdiv   <= (pdiv == PDIV_LAST) ? '0 : pdiv + PDIV_W'(1);
            end else if (tick) begin
                cnt <= cnt + PWM_BITWIDTH'(1);
            end
        end
    end

    // cnt never reaches 2^PWM_BITWIDTH-1, so the all-ones duty is constant high.
    assign pwm_o  = en_q && (cnt < duty_q);
    assign duty_o = duty_q;

endmodule

// File: tb/tb_pid_pwm_gen.sv
module tb_pid_pwm_gen;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              en_i;
    logic signed [8:0] pid_val_i;
    logic              pwm_o;
    logic              clk_en_PID_o;
    logic [3:0]        duty_o;
    logic              period_start_o;

    pid_pwm_gen #(
        .ADC_BITWIDTH (8),
        .PWM_BITWIDTH (4),
        .PRESCALE     (2),
        .PID_DIV      (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .pid_val_i      (pid_val_i),
        .pwm_o          (pwm_o),
        .clk_en_PID_o   (clk_en_PID_o),
        .duty_o         (duty_o),
        .period_start_o (period_start_o)
    );

    always #5 clk = ~clk;

    // Expected description of one PWM period, consumed when it starts.
    typedef struct {
        int duty;
        int hi;
        int ce;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   abort_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int duty, input int hi, input int ce);
        exp_t e;
        e.duty = duty;
        e.hi   = hi;
        e.ce   = ce;
        exp_q.push_back(e);
    endtask

    // Monitor: a period runs from one period_start_o pulse to the next.
    // At each start the expected entry is popped; at each close the measured
    // high time and length are compared. Aborted periods are discarded.
    exp_t cur;
    bit   open = 1'b0;
    int   hi_n = 0;
    int   len_n = 0;
    int   abort_seen = 0;

    always @(negedge clk) begin
        if (abort_cnt != abort_seen) begin
            abort_seen = abort_cnt;
            open = 1'b0;
        end
        if (period_start_o) begin
            if (open) begin
                chk("high_clocks", hi_n, cur.hi);
                chk("period_len", len_n, 30);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_period actual=period_start expected=none at %0t", $time);
                open = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                chk("duty_o", int'(duty_o), cur.duty);
                chk("clk_en_PID_o_at_start", int'(clk_en_PID_o), cur.ce);
                open  = 1'b1;
                hi_n  = 0;
                len_n = 0;
            end
        end else begin
            chk("stray_clk_en_PID_o", int'(clk_en_PID_o), 0);
        end
        if (open) begin
            len_n++;
            if (pwm_o) hi_n++;
        end
    end

    initial begin
        rst_i     = 1'b1;
        en_i      = 1'b0;
        pid_val_i = 9'sd0;
        step(3);
        chk("rst_pwm_o", int'(pwm_o), 0);
        chk("rst_clk_en_PID_o", int'(clk_en_PID_o), 0);
        chk("rst_duty_o", int'(duty_o), 0);
        chk("rst_period_start_o", int'(period_start_o), 0);
        rst_i = 1'b0;
        step(1);

        // Enable with mid-scale value; edge E0 is the next posedge.
        pid_val_i = 9'sd128;
        en_i      = 1'b1;
        push(8, 16, 0);
        push(8, 16, 0);
        push(8, 16, 0);
        push(8, 16, 0);
        push(8, 16, 1);   // 120 clocks after the first period start
        push(4, 8, 0);    // 128->64 mid period 4 takes effect here
        push(0, 0, 0);    // negative value clamps to 0
        push(15, 30, 0);  // 255 gives constant high
        step(131);
        pid_val_i = 9'sd64;
        step(30);
        pid_val_i = -9'sd5;
        step(30);
        pid_val_i = 9'sd255;
        step(30);
        pid_val_i = 9'sd128;
        push(8, 16, 1);   // period 8, aborted by reset
        step(25);

        // Reset in the high phase of period 8.
        chk("pwm_high_before_rst", int'(pwm_o), 1);
        rst_i = 1'b1;
        step(1);
        abort_cnt++;
        chk("midrst_pwm_o", int'(pwm_o), 0);
        chk("midrst_clk_en_PID_o", int'(clk_en_PID_o), 0);
        chk("midrst_duty_o", int'(duty_o), 0);
        chk("midrst_period_start_o", int'(period_start_o), 0);
        rst_i = 1'b0;
        push(8, 16, 0);
        push(8, 16, 0);
        push(8, 16, 0);
        push(8, 16, 0);   // period 12, aborted by enable drop
        step(120);

        // Drop enable in the wrap cycle that would have pulsed clk_en_PID_o.
        en_i = 1'b0;
        step(1);
        abort_cnt++;
        chk("endrop_pwm_o", int'(pwm_o), 0);
        chk("endrop_clk_en_PID_o", int'(clk_en_PID_o), 0);
        chk("endrop_period_start_o", int'(period_start_o), 0);
        step(1);
        chk("endrop2_clk_en_PID_o", int'(clk_en_PID_o), 0);
        pid_val_i = 9'sd64;
        step(1);
        chk("idle_duty_tracks", int'(duty_o), 4);
        chk("idle_pwm_o", int'(pwm_o), 0);
        step(1);

        // Re-enable with the duty already loaded while idle.
        push(4, 8, 0);
        push(4, 8, 0);
        en_i = 1'b1;
        step(35);

        chk("expected_periods_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
